program_sequencer_stack: RTL and testbench

PROGRAM_SEQUENCER_STACK -- requirements
Module: program_sequencer_stack

---
 rtl/program_sequencer_stack.sv | 134 +++++++++++++
 tb/tb_program_sequencer_stack.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer_stack.sv
// Program sequencer with a hardware return-address stack. It computes the next
// program-memory address combinationally and registers it as the program counter.
module program_sequencer_stack #(
    parameter int ADDR_W  = 8,
    parameter int JADDR_W = 4,
    parameter int DEPTH   = 4,
    parameter int SP_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               jmp,
    input  logic               jmp_nz,
    input  logic               dont_jmp,
    input  logic               call,
    input  logic               ret,
    input  logic               hold,
    input  logic [JADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  from_PS,
    output logic [SP_W-1:0]    sp,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_HOLD,
        SRC_TARGET,
        SRC_CALL,
        SRC_RET,
        SRC_INC
    } src_e;

    logic [ADDR_W-1:0] stack_mem [DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] top_entry;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              full_r;
    logic              empty_r;
    logic              push;
    logic              pop;
    logic              err_set;
    src_e              src;

    // The jump field selects the upper address bits; the low bits of the target are zero.
    assign target    = ADDR_W'(jmp_addr) << (ADDR_W - JADDR_W);
    assign pc_inc    = pc + ADDR_W'(1);
    assign full_r    = (sp == SP_FULL);
    assign empty_r   = (sp == '0);
    assign top_idx   = IDX_W'(sp - SP_W'(1));
    assign push_idx  = IDX_W'(sp);
    assign top_entry = stack_mem[top_idx];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        src     = SRC_INC;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (sync_reset) begin
            src = SRC_RESET;
        end else if (hold) begin
            src = SRC_HOLD;
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            src = SRC_TARGET;
        end else if (call) begin
            // A call always claims the cycle, even when refused, so a coincident ret is dropped.
            if (!full_r) begin
                src  = SRC_CALL;
                push = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end else if (ret) begin
            if (!empty_r) begin
                src = SRC_RET;
                pop = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_comb begin
        pm_addr = pc_inc;
        case (src)
            SRC_RESET:  pm_addr = '0;
            SRC_HOLD:   pm_addr = pc;
            SRC_TARGET: pm_addr = target;
            SRC_CALL:   pm_addr = target;
            SRC_RET:    pm_addr = top_entry;
            default:    pm_addr = pc_inc;
        endcase
    end

    // Stale entries above sp are masked here, and reset forces the idle view immediately.
    assign from_PS     = (sync_reset || empty_r) ? '0 : top_entry;
    assign stack_full  = full_r && !sync_reset;
    assign stack_empty = empty_r || sync_reset;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc        <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (push) begin
                sp <= sp + SP_W'(1);
            end else if (pop) begin
                sp <= sp - SP_W'(1);
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    // NOTE: the stack array has no reset; entries at or above sp are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack: a cycle-by-cycle vector table plus
// hand-written sequences for mid-subroutine reset and address wrap.
module tb_program_sequencer_stack;

    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic [2:0] sp;
    logic       stack_full, stack_empty, stack_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst, jmp, jnz, dj, call, ret, hold;
        logic [3:0] ja;
        logic [7:0] pm;   // expected pm_addr before the edge, and pc after it
        logic [2:0] sp;
        logic [7:0] top;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    program_sequencer_stack #(
        .ADDR_W (8),
        .JADDR_W(4),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .dont_jmp   (dont_jmp),
        .call       (call),
        .ret        (ret),
        .hold       (hold),
        .jmp_addr   (jmp_addr),
        .pm_addr    (pm_addr),
        .pc         (pc),
        .from_PS    (from_PS),
        .sp         (sp),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, j, jnz, dj, c, r, h,
                                input logic [3:0] ja, input logic [7:0] pm,
                                input logic [2:0] s, input logic [7:0] top, input logic e);
        vec_t v;
        v.rst = rst; v.jmp = j; v.jnz = jnz; v.dj = dj; v.call = c; v.ret = r; v.hold = h;
        v.ja = ja; v.pm = pm; v.sp = s; v.top = top; v.err = e;
        return v;
    endfunction

    task automatic drive(input logic rst, j, jnz, dj, c, r, h, input logic [3:0] ja);
        @(negedge clk);
        sync_reset = rst; jmp = j; jmp_nz = jnz; dont_jmp = dj;
        call = c; ret = r; hold = h; jmp_addr = ja;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 4'h0);
        tick();
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.jmp, v.jnz, v.dj, v.call, v.ret, v.hold, v.ja);
        #1;
        check($sformatf("v%0d pm_addr", idx), pm_addr, v.pm);
        tick();
        check($sformatf("v%0d pc", idx), pc, v.pm);
        check($sformatf("v%0d sp", idx), sp, v.sp);
        check($sformatf("v%0d from_PS", idx), from_PS, v.top);
        check($sformatf("v%0d stack_err", idx), stack_err, v.err);
        check($sformatf("v%0d stack_full", idx), stack_full, v.sp == 3'd4);
        check($sformatf("v%0d stack_empty", idx), stack_empty, v.sp == 3'd0);
    endtask

    initial begin
        sync_reset = 1'b1; jmp = 0; jmp_nz = 0; dont_jmp = 0;
        call = 0; ret = 0; hold = 0; jmp_addr = '0;

        //           rst j jnz dj c r h  ja     pm     sp  top    err
        // Reset, then idle count-up to 0x05.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h01, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h02, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h03, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h05, 0, 8'h00, 0));
        // Single call/return.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h3, 8'h30, 1, 8'h06, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h06, 0, 8'h00, 0));
        // Four nested calls, overflow, then unwind.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h1, 8'h10, 1, 8'h07, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h2, 8'h20, 2, 8'h11, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h3, 8'h30, 3, 8'h21, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h4, 8'h40, 4, 8'h31, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'h5, 8'h41, 4, 8'h31, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h31, 3, 8'h21, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h21, 2, 8'h11, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h11, 1, 8'h07, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h07, 0, 8'h00, 1));
        // Reset overrides a simultaneous call; then underflow.
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'h9, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'h0, 8'h01, 0, 8'h00, 1));
        // Conditional jump not taken / taken.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'h1, 8'h10, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h11, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h12, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'hA, 8'h13, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'hA, 8'hA0, 0, 8'h00, 1));
        // call and ret together: call wins.
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'h2, 8'h20, 1, 8'hA1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 8'h21, 1, 8'hA1, 1));
        // hold two cycles with call asserted: no push.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h5, 8'h21, 1, 8'hA1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h5, 8'h21, 1, 8'hA1, 1));
        // jmp suppresses call; taken jmp_nz suppresses ret; untaken jmp_nz lets ret through.
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 4'h6, 8'h60, 1, 8'hA1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h7, 8'h70, 1, 8'hA1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'h7, 8'hA1, 0, 8'h00, 1));

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset asserted mid-subroutine with sp = 2 and stack_err set.
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 4'h0); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 4'h1); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 4'h2); tick();
        check("mid sp before reset", sp, 3'd2);
        check("mid err before reset", stack_err, 1'b1);
        check("mid from_PS before reset", from_PS, 8'h11);
        drive(1, 0, 0, 0, 1, 0, 0, 4'h3);
        #1;
        check("rst pm_addr", pm_addr, 8'h00);
        check("rst from_PS", from_PS, 8'h00);
        check("rst stack_empty", stack_empty, 1'b1);
        check("rst stack_full", stack_full, 1'b0);
        tick();
        check("post-rst pc", pc, 8'h00);
        check("post-rst sp", sp, 3'd0);
        check("post-rst stack_err", stack_err, 1'b0);
        check("post-rst from_PS", from_PS, 8'h00);
        idle();
        check("post-rst idle pc", pc, 8'h01);
        check("post-rst idle from_PS", from_PS, 8'h00);
        check("post-rst idle empty", stack_empty, 1'b1);

        // Address wrap: idle at 0xFF goes to 0x00; a call at 0xFF pushes 0x00.
        drive(0, 1, 0, 0, 0, 0, 0, 4'hF); tick();
        for (int i = 0; i < 15; i++) idle();
        check("wrap pc at ff", pc, 8'hFF);
        drive(0, 0, 0, 0, 0, 0, 0, 4'h0);
        #1;
        check("wrap pm_addr", pm_addr, 8'h00);
        tick();
        check("wrap pc", pc, 8'h00);
        drive(0, 1, 0, 0, 0, 0, 0, 4'hF); tick();
        for (int i = 0; i < 15; i++) idle();
        drive(0, 0, 0, 0, 1, 0, 0, 4'h1); tick();
        check("call at ff pc", pc, 8'h10);
        check("call at ff from_PS", from_PS, 8'h00);
        check("call at ff sp", sp, 3'd1);
        drive(0, 0, 0, 0, 0, 1, 0, 4'h0); tick();
        check("ret to 00 pc", pc, 8'h00);
        check("ret to 00 sp", sp, 3'd0);
        check("wrap stack_err", stack_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
